// File: rtl/vertex_streamer.sv
// Snapshots a parallel set of {x,y,z} vertices on start and streams it out
// one vertex per valid/ready beat, isolated from later bus changes.
module vertex_streamer #(
    parameter int MAX_VERTS = 12,
    parameter int COORD_W   = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [MAX_VERTS*3*COORD_W-1:0] vert_bus,
    input  logic [3:0]                     num_verts,
    input  logic                           start,
    output logic                           busy,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [COORD_W-1:0]             out_x,
    output logic [COORD_W-1:0]             out_y,
    output logic [COORD_W-1:0]             out_z,
    output logic [3:0]                     out_index,
    output logic                           out_last,
    output logic                           done
);

    localparam int         VERT_W  = 3 * COORD_W;
    localparam logic [3:0] MAX_CNT = 4'(MAX_VERTS);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [VERT_W-1:0] snap [MAX_VERTS];
    logic [3:0]        cnt;
    logic [3:0]        idx;
    logic [3:0]        cnt_in;
    logic [VERT_W-1:0] cur;
    logic              at_last;
    logic              accept;

    // Counts above the slot count are clamped rather than rejected.
    assign cnt_in  = (num_verts > MAX_CNT) ? MAX_CNT : num_verts;
    assign at_last = (idx == cnt - 4'd1);
    assign accept  = (state == IDLE) && start;
    assign cur     = snap[idx];

    assign out_x     = cur[VERT_W-1 -: COORD_W];
    assign out_y     = cur[2*COORD_W-1 -: COORD_W];
    assign out_z     = cur[COORD_W-1:0];
    assign out_index = idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // idx only advances on a non-final transfer, so it never passes cnt-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 4'd0;
            idx <= 4'd0;
            for (int k = 0; k < MAX_VERTS; k++) begin
                snap[k] <= '0;
            end
        end else if (accept) begin
            cnt <= cnt_in;
            idx <= 4'd0;
            for (int k = 0; k < MAX_VERTS; k++) begin
                snap[k] <= vert_bus[k*VERT_W +: VERT_W];
            end
        end else if (state == STREAM && out_ready && !at_last) begin
            idx <= idx + 4'd1;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = (cnt_in == 4'd0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = at_last;
                if (out_ready && at_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vertex_streamer.sv
// Randomized self-checking bench for vertex_streamer; expected beats come from
// a queue built directly from the snapshot-and-clamp rule.
module tb_vertex_streamer;

    localparam int MAXV = 12;
    localparam int CW   = 16;
    localparam int VW   = 3 * CW;
    localparam int BW   = MAXV * VW;

    logic          clk = 1'b0;
    logic          reset;
    logic [BW-1:0] vert_bus;
    logic [3:0]    num_verts;
    logic          start;
    logic          busy;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_x;
    logic [CW-1:0] out_y;
    logic [CW-1:0] out_z;
    logic [3:0]    out_index;
    logic          out_last;
    logic          done;

    int checks   = 0;
    int failures = 0;

    vertex_streamer #(.MAX_VERTS(MAXV), .COORD_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .vert_bus  (vert_bus),
        .num_verts (num_verts),
        .start     (start),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_z     (out_z),
        .out_index (out_index),
        .out_last  (out_last),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] rand_bus();
        logic [BW-1:0] b;
        logic [63:0]   r;
        for (int k = 0; k < MAXV; k++) begin
            r = {$urandom(), $urandom()};
            b[k*VW +: VW] = r[VW-1:0];
        end
        return b;
    endfunction

    // Corners of a +/-2.0 cube; v0 and v7 are pinned to the reference set.
    function automatic logic [BW-1:0] cube_bus();
        logic [BW-1:0] b;
        logic [CW-1:0] x, y, z;
        b = '0;
        for (int k = 0; k < 8; k++) begin
            x = ((k & 4) != 0) ? 16'h0200 : 16'hFE00;
            y = ((k & 2) != 0) ? 16'h0200 : 16'hFE00;
            z = ((k & 1) != 0) ? 16'h0200 : 16'hFE00;
            b[k*VW +: VW] = {x, y, z};
        end
        b[7*VW +: VW] = {16'hFE00, 16'h0200, 16'h0200};
        return b;
    endfunction

    task automatic test_reset();
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        vert_bus  = '0;
        num_verts = 4'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, out_valid, out_last, done} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_flags: got %b expected 0000", {busy, out_valid, out_last, done});
        end
        checks++;
        if ({out_x, out_y, out_z, out_index} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_data: got %h/%h/%h idx %0d expected all zero", out_x, out_y, out_z, out_index);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // ready_mode: 0 = always ready, 1 = fixed 0,0,1,0,1,1,1 pattern, 2 = random.
    task automatic test_stream(input string name, input logic [BW-1:0] bus, input logic [3:0] n,
                               input int ready_mode, input int restart_at);
        logic [VW-1:0] exp_q[$];
        logic [6:0]    pat;
        logic          r;
        int            m, ptr, cyc;
        pat = 7'b1110100;
        m   = (int'(n) > MAXV) ? MAXV : int'(n);
        for (int k = 0; k < m; k++) exp_q.push_back(bus[k*VW +: VW]);

        vert_bus  = bus;
        num_verts = n;
        start     = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;

        ptr = 0;
        cyc = 0;
        while (ptr < m && cyc < 300) begin
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("[TB] FAIL %s beat%0d ctrl: got valid=%b busy=%b done=%b expected 1 1 0",
                         name, ptr, out_valid, busy, done);
            end
            checks++;
            if ({out_x, out_y, out_z} !== exp_q[ptr] || out_index !== 4'(ptr) || out_last !== (ptr == m - 1)) begin
                failures++;
                $display("[TB] FAIL %s beat%0d data: got %h idx=%0d last=%b expected %h idx=%0d last=%b",
                         name, ptr, {out_x, out_y, out_z}, out_index, out_last, exp_q[ptr], ptr, (ptr == m - 1));
            end
            case (ready_mode)
                0:       r = 1'b1;
                1:       r = pat[cyc % 7];
                default: r = 1'($urandom_range(0, 1));
            endcase
            out_ready = r;
            start     = (cyc == restart_at);
            vert_bus  = rand_bus();
            num_verts = start ? 4'd6 : 4'($urandom_range(0, 15));
            @(negedge clk);
            cyc++;
            if (r) ptr++;
        end
        start = 1'b0;

        checks++;
        if (ptr != m) begin
            failures++;
            $display("[TB] FAIL %s timeout: got %0d transfers expected %0d", name, ptr, m);
        end
        if (ready_mode == 0) begin
            checks++;
            if (cyc != m) begin
                failures++;
                $display("[TB] FAIL %s beat_count: got %0d cycles expected %0d", name, cyc, m);
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s done_pulse: got done=%b busy=%b valid=%b expected 1 1 0",
                     name, done, busy, out_valid);
        end
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL %s idle%0d: got done=%b busy=%b valid=%b expected 0 0 0",
                         name, i, done, busy, out_valid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midstream();
        logic [BW-1:0] bus;
        bus       = rand_bus();
        vert_bus  = bus;
        num_verts = 4'd8;
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_index !== 4'd4 || {out_x, out_y, out_z} !== bus[4*VW +: VW]) begin
            failures++;
            $display("[TB] FAIL mid_index4: got valid=%b idx=%0d data=%h expected 1 4 %h",
                     out_valid, out_index, {out_x, out_y, out_z}, bus[4*VW +: VW]);
        end
        out_ready = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_index !== 4'd0 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_reset: got valid=%b busy=%b idx=%0d done=%b expected 0 0 0 0",
                     out_valid, busy, out_index, done);
        end
        for (int i = 0; i < 3; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || out_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL mid_no_done%0d: got done=%b valid=%b expected 0 0", i, done, out_valid);
            end
        end
        test_stream("after_reset", rand_bus(), 4'd8, 0, -1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_stream("cube", cube_bus(), 4'd8, 0, -1);
        test_stream("tetra_bp", rand_bus(), 4'd4, 1, -1);
        test_stream("zero", rand_bus(), 4'd0, 0, -1);
        test_stream("clamp15", rand_bus(), 4'd15, 0, -1);
        test_stream("restart_ignored", cube_bus(), 4'd8, 0, 2);
        test_reset_midstream();
        for (int i = 0; i < 6; i++) begin
            test_stream("random", rand_bus(), 4'($urandom_range(0, 15)), 2, -1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
